// File: rtl/charram_access_ctrl_pkg.sv
// Shared definitions for the character-RAM access sequencer: FSM encoding,
// byte-lane indices and the CPU lane-select decode.
package charram_access_ctrl_pkg;

  localparam int ROW_W = 14;

  // Lane k drives SELk_n; lane 0 carries bits 31:24, lane 3 carries bits 7:0.
  localparam int LANE_0 = 0;
  localparam int LANE_1 = 1;
  localparam int LANE_2 = 2;
  localparam int LANE_3 = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_CPU_HOLD = 2'd3
  } state_e;

  // A1 picks the 16-bit half; UDS maps to the upper byte of that half.
  function automatic logic [3:0] cpu_sel_n(input logic a1, input logic uds_n, input logic lds_n);
    logic [3:0] sel_n;
    sel_n = 4'hF;
    if (a1) begin
      sel_n[LANE_2] = uds_n;
      sel_n[LANE_3] = lds_n;
    end else begin
      sel_n[LANE_0] = uds_n;
      sel_n[LANE_1] = lds_n;
    end
    return sel_n;
  endfunction

endpackage

// File: rtl/charram_access_ctrl.sv
// Two-master sequencer for the 16k x 32 byte-laned character RAM: the 68000
// (16-bit, UDS/LDS, DTACK handshake) and the 32-bit video tile fetcher.
module charram_access_ctrl
  import charram_access_ctrl_pkg::*;
#(
  parameter int P_VID_PRIO   = 1,
  parameter int P_CPU_STARVE = 8
) (
  input  logic             i_EMU_MCLK,
  input  logic             i_EMU_RST,
  input  logic             i_CPU_AS_n,
  input  logic             i_CPU_RW,
  input  logic             i_CPU_UDS_n,
  input  logic             i_CPU_LDS_n,
  input  logic [14:0]      i_CPU_ADDR,
  input  logic [15:0]      i_CPU_DIN,
  output logic [15:0]      o_CPU_DOUT,
  output logic             o_CPU_DTACK_n,
  input  logic             i_VID_REQ,
  input  logic [ROW_W-1:0] i_VID_ADDR,
  output logic [31:0]      o_VID_DATA,
  output logic             o_VID_ACK,
  output logic [ROW_W-1:0] o_RAM_ADDR,
  output logic [31:0]      o_RAM_DIN,
  output logic             o_RAM_WR_n,
  output logic             o_RAM_RD_n,
  output logic [3:0]       o_RAM_SEL_n,
  input  logic [31:0]      i_RAM_DOUT
);

  localparam int STARVE_W = (P_CPU_STARVE < 1) ? 1 : $clog2(P_CPU_STARVE + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'((P_CPU_STARVE < 0) ? 0 : P_CPU_STARVE);

  state_e               state_q;
  logic [STARVE_W-1:0]  starve_q, starve_d;
  logic                 is_vid_q, is_wr_q, a1_q;
  logic [ROW_W-1:0]     ram_addr_q;
  logic [31:0]          ram_din_q;
  logic                 ram_wr_n_q, ram_rd_n_q;
  logic [3:0]           ram_sel_n_q;
  logic [15:0]          cpu_dout_q;
  logic                 cpu_dtack_n_q;
  logic [31:0]          vid_data_q;
  logic                 vid_ack_q;

  logic cpu_req, grant_cpu, grant_vid;

  // CPU_HOLD keeps the FSM away from IDLE until AS_n rises, so a request seen
  // in IDLE is always a fresh bus cycle.
  assign cpu_req = !i_CPU_AS_n && (!i_CPU_UDS_n || !i_CPU_LDS_n);

  always_comb begin
    grant_cpu = 1'b0;
    grant_vid = 1'b0;
    if (cpu_req && i_VID_REQ) begin
      if (starve_q >= STARVE_MAX) grant_cpu = 1'b1;
      else if (P_VID_PRIO != 0)   grant_vid = 1'b1;
      else                        grant_cpu = 1'b1;
    end else if (cpu_req) begin
      grant_cpu = 1'b1;
    end else if (i_VID_REQ) begin
      grant_vid = 1'b1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (state_q == ST_IDLE) begin
      if (grant_cpu)
        starve_d = '0;
      else if (grant_vid && cpu_req && (starve_q < STARVE_MAX))
        starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_RST) begin
    if (i_EMU_RST) begin
      state_q       <= ST_IDLE;
      starve_q      <= '0;
      is_vid_q      <= 1'b0;
      is_wr_q       <= 1'b0;
      a1_q          <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      ram_wr_n_q    <= 1'b1;
      ram_rd_n_q    <= 1'b1;
      ram_sel_n_q   <= 4'hF;
      cpu_dout_q    <= '0;
      cpu_dtack_n_q <= 1'b1;
      vid_data_q    <= '0;
      vid_ack_q     <= 1'b0;
    end else begin
      starve_q <= starve_d;
      case (state_q)
        ST_IDLE: begin
          if (grant_vid) begin
            ram_addr_q  <= i_VID_ADDR;
            ram_rd_n_q  <= 1'b0;
            ram_sel_n_q <= 4'h0;
            is_vid_q    <= 1'b1;
            is_wr_q     <= 1'b0;
            state_q     <= ST_ISSUE;
          end else if (grant_cpu) begin
            ram_addr_q  <= i_CPU_ADDR[14:1];
            ram_din_q   <= {i_CPU_DIN, i_CPU_DIN};
            ram_rd_n_q  <= !i_CPU_RW;
            ram_wr_n_q  <= i_CPU_RW;
            ram_sel_n_q <= cpu_sel_n(i_CPU_ADDR[0], i_CPU_UDS_n, i_CPU_LDS_n);
            is_vid_q    <= 1'b0;
            is_wr_q     <= !i_CPU_RW;
            a1_q        <= i_CPU_ADDR[0];
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          ram_rd_n_q  <= 1'b1;
          ram_wr_n_q  <= 1'b1;
          ram_sel_n_q <= 4'hF;
          state_q     <= ST_CAPTURE;
          // RAM answers on the negedge inside ISSUE; latching here presents
          // data and ACK/DTACK throughout CAPTURE.
          if (is_vid_q) begin
            vid_data_q <= i_RAM_DOUT;
            vid_ack_q  <= 1'b1;
          end else begin
            if (!is_wr_q)
              cpu_dout_q <= a1_q ? i_RAM_DOUT[15:0] : i_RAM_DOUT[31:16];
            cpu_dtack_n_q <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          vid_ack_q <= 1'b0;
          state_q   <= is_vid_q ? ST_IDLE : ST_CPU_HOLD;
        end
        ST_CPU_HOLD: begin
          if (i_CPU_AS_n) begin
            cpu_dtack_n_q <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_RAM_ADDR    = ram_addr_q;
  assign o_RAM_DIN     = ram_din_q;
  assign o_RAM_WR_n    = ram_wr_n_q;
  assign o_RAM_RD_n    = ram_rd_n_q;
  assign o_RAM_SEL_n   = ram_sel_n_q;
  assign o_CPU_DOUT    = cpu_dout_q;
  assign o_CPU_DTACK_n = cpu_dtack_n_q;
  assign o_VID_DATA    = vid_data_q;
  assign o_VID_ACK     = vid_ack_q;

endmodule

// File: tb/tb_charram_access_ctrl.sv
// Scoreboard bench for charram_access_ctrl with a byte-laned RAM model that
// samples strobes on the falling clock edge.
module tb_charram_access_ctrl;

  logic        clk = 1'b0, rst = 1'b0;
  logic        as_n = 1'b1, rw = 1'b1, uds_n = 1'b1, lds_n = 1'b1;
  logic [14:0] cpu_addr = '0;
  logic [15:0] cpu_din = '0, cpu_dout;
  logic        dtack_n;
  logic        vid_req = 1'b0;
  logic [13:0] vid_addr = '0;
  logic [31:0] vid_data;
  logic        vid_ack;
  logic [13:0] ram_addr;
  logic [31:0] ram_din, ram_dout = '0;
  logic        ram_wr_n, ram_rd_n;
  logic [3:0]  ram_sel_n;

  int n_checks = 0, n_fail = 0;

  logic [31:0] mem [0:16383];
  logic        pl_en = 1'b0;
  logic [13:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  logic [15:0] exp_cpu_q [$];
  logic [31:0] exp_vid_q [$];

  int          strobe_cnt = 0;
  logic [3:0]  last_sel = 4'hF;
  logic        last_wr_n = 1'b1, last_rd_n = 1'b1;
  logic [13:0] last_addr = '0;
  logic [31:0] last_din = '0;

  always #5 clk = ~clk;

  charram_access_ctrl #(.P_VID_PRIO(1), .P_CPU_STARVE(8)) dut (
    .i_EMU_MCLK(clk), .i_EMU_RST(rst),
    .i_CPU_AS_n(as_n), .i_CPU_RW(rw), .i_CPU_UDS_n(uds_n), .i_CPU_LDS_n(lds_n),
    .i_CPU_ADDR(cpu_addr), .i_CPU_DIN(cpu_din), .o_CPU_DOUT(cpu_dout), .o_CPU_DTACK_n(dtack_n),
    .i_VID_REQ(vid_req), .i_VID_ADDR(vid_addr), .o_VID_DATA(vid_data), .o_VID_ACK(vid_ack),
    .o_RAM_ADDR(ram_addr), .o_RAM_DIN(ram_din), .o_RAM_WR_n(ram_wr_n), .o_RAM_RD_n(ram_rd_n),
    .o_RAM_SEL_n(ram_sel_n), .i_RAM_DOUT(ram_dout)
  );

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] sel_n);
    logic [31:0] w;
    w = old;
    for (int k = 0; k < 4; k++)
      if (!sel_n[k]) w[31-8*k -: 8] = d[31-8*k -: 8];
    return w;
  endfunction

  // RAM element model plus a strobe recorder.
  always @(negedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (!ram_wr_n) mem[ram_addr] <= merge_bytes(mem[ram_addr], ram_din, ram_sel_n);
    if (!ram_rd_n) ram_dout <= mem[ram_addr];
    if (!ram_wr_n || !ram_rd_n) begin
      strobe_cnt <= strobe_cnt + 1;
      last_sel   <= ram_sel_n;
      last_wr_n  <= ram_wr_n;
      last_rd_n  <= ram_rd_n;
      last_addr  <= ram_addr;
      last_din   <= ram_din;
    end
  end

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic cpu_cycle(input logic rw_i, input logic [14:0] a, input logic u_n, input logic l_n,
                           input logic [15:0] d, output logic got, output int lat,
                           output logic held, output logic rel);
    got = 1'b0; rel = 1'b0; held = 1'b0; lat = 0;
    @(posedge clk); #1;
    rw = rw_i; cpu_addr = a; uds_n = u_n; lds_n = l_n; cpu_din = d; as_n = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); lat++;
      @(negedge clk); if (dtack_n === 1'b0) got = 1'b1;
    end
    @(posedge clk); #1;
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    for (int i = 0; i < 8 && !rel; i++) begin
      @(negedge clk);
      if (i == 0) held = (dtack_n === 1'b0);
      if (dtack_n === 1'b1) rel = 1'b1;
    end
    $display("cpu %s a=%h uds_n=%b lds_n=%b din=%h dout=%h dtack=%b lat=%0d",
             rw_i ? "rd" : "wr", a, u_n, l_n, d, cpu_dout, got, lat);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (ram_wr_n !== 1'b1) begin n_fail++; $display("FAIL rst_wr_n: got %b expected 1", ram_wr_n); end
    n_checks++; if (ram_rd_n !== 1'b1) begin n_fail++; $display("FAIL rst_rd_n: got %b expected 1", ram_rd_n); end
    n_checks++; if (ram_sel_n !== 4'hF) begin n_fail++; $display("FAIL rst_sel_n: got %h expected f", ram_sel_n); end
    n_checks++; if (ram_addr !== 14'd0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", ram_addr); end
    n_checks++; if (dtack_n !== 1'b1) begin n_fail++; $display("FAIL rst_dtack: got %b expected 1", dtack_n); end
    n_checks++; if (vid_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b expected 0", vid_ack); end
    n_checks++; if (cpu_dout !== 16'h0) begin n_fail++; $display("FAIL rst_cpu_dout: got %h expected 0", cpu_dout); end
    n_checks++; if (vid_data !== 32'h0) begin n_fail++; $display("FAIL rst_vid_data: got %h expected 0", vid_data); end
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_cpu_write();
    logic got, held, rel; int lat, s0;
    preload(14'd1, 32'h0000_5A5A);
    s0 = strobe_cnt;
    cpu_cycle(1'b0, 15'h0002, 1'b0, 1'b0, 16'hBEEF, got, lat, held, rel);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL wr_dtack: got %b expected 1", got); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL wr_latency: got %0d expected 2", lat); end
    n_checks++; if (strobe_cnt - s0 != 1) begin n_fail++; $display("FAIL wr_strobe_cycles: got %0d expected 1", strobe_cnt - s0); end
    n_checks++; if (last_sel !== 4'b1100) begin n_fail++; $display("FAIL wr_sel: got %b expected 1100", last_sel); end
    n_checks++; if (last_wr_n !== 1'b0 || last_rd_n !== 1'b1) begin n_fail++; $display("FAIL wr_strobes: got wr_n=%b rd_n=%b expected 0/1", last_wr_n, last_rd_n); end
    n_checks++; if (last_addr !== 14'd1) begin n_fail++; $display("FAIL wr_addr: got %h expected 1", last_addr); end
    n_checks++; if (last_din !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL wr_din: got %h expected beefbeef", last_din); end
    n_checks++; if (held !== 1'b1 || rel !== 1'b1) begin n_fail++; $display("FAIL wr_dtack_release: got held=%b rel=%b expected 1/1", held, rel); end
    n_checks++; if (mem[1] !== 32'hBEEF_5A5A) begin n_fail++; $display("FAIL wr_mem: got %h expected beef5a5a", mem[1]); end
  endtask

  task automatic test_cpu_read();
    logic got, held, rel; int lat; logic [15:0] e;
    exp_cpu_q.push_back(16'hBEEF);
    cpu_cycle(1'b1, 15'h0002, 1'b0, 1'b0, 16'h0, got, lat, held, rel);
    e = exp_cpu_q.pop_front();
    n_checks++; if (got !== 1'b1 || cpu_dout !== e) begin n_fail++; $display("FAIL rd_hi: got dtack=%b dout=%h expected 1/%h", got, cpu_dout, e); end
    n_checks++; if (last_sel !== 4'b1100 || last_rd_n !== 1'b0) begin n_fail++; $display("FAIL rd_hi_strobes: got sel=%b rd_n=%b expected 1100/0", last_sel, last_rd_n); end
    exp_cpu_q.push_back(16'h5A5A);
    cpu_cycle(1'b1, 15'h0003, 1'b0, 1'b0, 16'h0, got, lat, held, rel);
    e = exp_cpu_q.pop_front();
    n_checks++; if (got !== 1'b1 || cpu_dout !== e) begin n_fail++; $display("FAIL rd_lo: got dtack=%b dout=%h expected 1/%h", got, cpu_dout, e); end
    n_checks++; if (last_sel !== 4'b0011) begin n_fail++; $display("FAIL rd_lo_sel: got %b expected 0011", last_sel); end
  endtask

  task automatic test_byte_write();
    logic got, held, rel; int lat; logic [15:0] e;
    preload(14'd5, 32'h1122_3344);
    cpu_cycle(1'b0, {14'd5, 1'b1}, 1'b1, 1'b0, 16'h1234, got, lat, held, rel);
    n_checks++; if (last_sel !== 4'b0111) begin n_fail++; $display("FAIL bw_lds_sel: got %b expected 0111", last_sel); end
    n_checks++; if (mem[5] !== 32'h1122_3334) begin n_fail++; $display("FAIL bw_lds_mem: got %h expected 11223334", mem[5]); end
    cpu_cycle(1'b0, {14'd5, 1'b0}, 1'b0, 1'b1, 16'hABCD, got, lat, held, rel);
    n_checks++; if (last_sel !== 4'b1110) begin n_fail++; $display("FAIL bw_uds_sel: got %b expected 1110", last_sel); end
    n_checks++; if (mem[5] !== 32'hAB22_3334) begin n_fail++; $display("FAIL bw_uds_mem: got %h expected ab223334", mem[5]); end
    exp_cpu_q.push_back(16'h3334);
    cpu_cycle(1'b1, {14'd5, 1'b1}, 1'b1, 1'b0, 16'h0, got, lat, held, rel);
    e = exp_cpu_q.pop_front();
    n_checks++; if (got !== 1'b1 || cpu_dout !== e) begin n_fail++; $display("FAIL bw_readback: got dtack=%b dout=%h expected 1/%h", got, cpu_dout, e); end
  endtask

  task automatic test_video();
    int acks, first_lat, s0; logic [31:0] got_data, e;
    preload(14'h3FFF, 32'hDEAD_BEEF);
    exp_vid_q.push_back(32'hDEAD_BEEF);
    s0 = strobe_cnt; acks = 0; first_lat = -1; got_data = '0;
    @(posedge clk); #1;
    vid_addr = 14'h3FFF; vid_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (acks > 0) vid_req = 1'b0;
      @(negedge clk);
      if (vid_ack === 1'b1) begin
        acks++;
        if (acks == 1) begin first_lat = i + 1; got_data = vid_data; end
      end
    end
    $display("vid rd a=3fff data=%h acks=%0d lat=%0d", got_data, acks, first_lat);
    e = (exp_vid_q.size() > 0) ? exp_vid_q.pop_front() : 32'hxxxx_xxxx;
    n_checks++; if (acks != 1) begin n_fail++; $display("FAIL vid_ack_count: got %0d expected 1", acks); end
    n_checks++; if (first_lat != 2) begin n_fail++; $display("FAIL vid_latency: got %0d expected 2", first_lat); end
    n_checks++; if (got_data !== e) begin n_fail++; $display("FAIL vid_data: got %h expected %h", got_data, e); end
    n_checks++; if (last_sel !== 4'b0000 || last_rd_n !== 1'b0 || last_addr !== 14'h3FFF) begin n_fail++; $display("FAIL vid_strobes: got sel=%b rd_n=%b addr=%h expected 0000/0/3fff", last_sel, last_rd_n, last_addr); end
    n_checks++; if (strobe_cnt - s0 != 1) begin n_fail++; $display("FAIL vid_strobe_cycles: got %0d expected 1", strobe_cnt - s0); end
    n_checks++; if (vid_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL vid_data_hold: got %h expected deadbeef", vid_data); end
  endtask

  task automatic test_starve();
    int vacks, vid_before; logic cpu_done, rel; logic [31:0] e32; logic [15:0] e16;
    for (int i = 0; i < 10; i++) preload(14'h100 + 14'(i), 32'hC0DE_0000 + 32'(i));
    preload(14'h20, 32'h7777_8888);
    vacks = 0; vid_before = -1; cpu_done = 1'b0; rel = 1'b0;
    exp_cpu_q.push_back(16'h7777);
    exp_vid_q.push_back(32'hC0DE_0000);
    @(posedge clk); #1;
    vid_addr = 14'h100; vid_req = 1'b1;
    cpu_addr = {14'h20, 1'b0}; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    for (int i = 0; i < 120 && !cpu_done; i++) begin
      @(negedge clk);
      if (vid_ack === 1'b1) begin
        e32 = exp_vid_q.pop_front(); vacks++;
        $display("vid rd a=%h data=%h", vid_addr, vid_data);
        n_checks++; if (vid_data !== e32) begin n_fail++; $display("FAIL starve_vid_data: got %h expected %h", vid_data, e32); end
        vid_addr = 14'h100 + 14'(vacks);
        exp_vid_q.push_back(32'hC0DE_0000 + 32'(vacks));
      end
      if (dtack_n === 1'b0) begin cpu_done = 1'b1; vid_before = vacks; end
    end
    $display("cpu rd a=%h dout=%h after %0d video grants", cpu_addr, cpu_dout, vid_before);
    e16 = exp_cpu_q.pop_front();
    n_checks++; if (cpu_done !== 1'b1) begin n_fail++; $display("FAIL starve_cpu_served: got %b expected 1", cpu_done); end
    n_checks++; if (vid_before != 8) begin n_fail++; $display("FAIL starve_grants: got %0d expected 8", vid_before); end
    n_checks++; if (cpu_dout !== e16) begin n_fail++; $display("FAIL starve_cpu_data: got %h expected %h", cpu_dout, e16); end
    @(posedge clk); #1;
    vid_req = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    for (int i = 0; i < 8 && !rel; i++) begin @(negedge clk); if (dtack_n === 1'b1) rel = 1'b1; end
    n_checks++; if (rel !== 1'b1) begin n_fail++; $display("FAIL starve_dtack_release: got %b expected 1", rel); end
    exp_vid_q.delete();
  endtask

  task automatic test_back_to_back();
    int dtack_at, ack_at, acks; logic [15:0] e16; logic [31:0] e32, got_vid;
    dtack_at = -1; ack_at = -1; acks = 0; got_vid = '0;
    exp_cpu_q.push_back(16'h8888);
    exp_vid_q.push_back(32'hC0DE_0005);
    @(posedge clk); #1;
    cpu_addr = {14'h20, 1'b1}; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    @(posedge clk); #1;
    vid_addr = 14'h105; vid_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (dtack_at >= 0) begin as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; end
      if (ack_at >= 0) vid_req = 1'b0;
      @(negedge clk);
      if (dtack_n === 1'b0 && dtack_at < 0) dtack_at = i;
      if (vid_ack === 1'b1) begin acks++; if (ack_at < 0) begin ack_at = i; got_vid = vid_data; end end
    end
    $display("b2b cpu dout=%h at %0d, vid data=%h at %0d", cpu_dout, dtack_at, got_vid, ack_at);
    e16 = exp_cpu_q.pop_front();
    e32 = exp_vid_q.pop_front();
    n_checks++; if (dtack_at < 0 || cpu_dout !== e16) begin n_fail++; $display("FAIL b2b_cpu: got dtack_at=%0d dout=%h expected served/%h", dtack_at, cpu_dout, e16); end
    n_checks++; if (acks != 1 || got_vid !== e32) begin n_fail++; $display("FAIL b2b_vid: got acks=%0d data=%h expected 1/%h", acks, got_vid, e32); end
    n_checks++; if (!(ack_at > dtack_at)) begin n_fail++; $display("FAIL b2b_order: got ack_at=%0d dtack_at=%0d expected ack after dtack", ack_at, dtack_at); end
  endtask

  task automatic test_reset_mid();
    logic got, held, rel; int lat, bad; logic [15:0] e;
    preload(14'd7, 32'h0102_0304);
    @(posedge clk); #1;
    cpu_addr = {14'd7, 1'b0}; rw = 1'b0; uds_n = 1'b0; lds_n = 1'b0; cpu_din = 16'hFFFF; as_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (ram_wr_n !== 1'b0) begin n_fail++; $display("FAIL mid_in_issue: got wr_n=%b expected 0", ram_wr_n); end
    rst = 1'b1; #1;
    n_checks++; if (ram_wr_n !== 1'b1 || ram_rd_n !== 1'b1 || ram_sel_n !== 4'hF) begin n_fail++; $display("FAIL mid_strobes: got wr_n=%b rd_n=%b sel=%b expected 1/1/1111", ram_wr_n, ram_rd_n, ram_sel_n); end
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (dtack_n !== 1'b1 || vid_ack !== 1'b0) bad++; end
    $display("reset during write issue, released");
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mid_no_ack: got %0d handshake cycles expected 0", bad); end
    n_checks++; if (mem[7] !== 32'h0102_0304) begin n_fail++; $display("FAIL mid_mem: got %h expected 01020304", mem[7]); end
    exp_cpu_q.push_back(16'h0102);
    cpu_cycle(1'b1, {14'd7, 1'b0}, 1'b0, 1'b0, 16'h0, got, lat, held, rel);
    e = exp_cpu_q.pop_front();
    n_checks++; if (got !== 1'b1 || lat != 2 || cpu_dout !== e) begin n_fail++; $display("FAIL mid_idle_after: got dtack=%b lat=%0d dout=%h expected 1/2/%h", got, lat, cpu_dout, e); end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_byte_write();
    test_video();
    test_starve();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got time limit expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
